decode_buffer: RTL and testbench

DECODE_BUFFER -- requirements
Module: decode_buffer

---
 rtl/cpu_types_pkg.sv | 88 ++++++++
 rtl/decode_core.sv | 131 +++++++++++++
 rtl/decode_buffer.sv | 97 +++++++++
 tb/tb_decode_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared RV32 decode types: opcodes, funct3 groups, ALU ops and the
// decoded bundle handed from the decode buffer to execute.
package cpu_types_pkg;

  typedef enum logic [6:0] {
    RTYPE  = 7'b0110011,
    ITYPE  = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    ATOMIC = 7'b0101111,
    HALT   = 7'b1111111
  } opcode_t;

  typedef enum logic [2:0] {
    F3_ADD, F3_SLL, F3_SLT, F3_SLTU,
    F3_XOR, F3_SR, F3_OR, F3_AND
  } funct3_r_t;

  typedef enum logic [2:0] {
    BEQ  = 3'd0, BNE  = 3'd1,
    BLT  = 3'd4, BGE  = 3'd5,
    BLTU = 3'd6, BGEU = 3'd7
  } funct3_b_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluop_t;

  typedef enum logic {RUN, HALTED} intake_t;

  // rdSel: writeback source for rd
  localparam logic [2:0] RD_ALU   = 3'd0;
  localparam logic [2:0] RD_MEM   = 3'd1;
  localparam logic [2:0] RD_PC4   = 3'd2;
  localparam logic [2:0] RD_IMM   = 3'd3;
  localparam logic [2:0] RD_AUIPC = 3'd4;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [4:0] AMO_LR  = 5'b00010;
  localparam logic [4:0] AMO_SC  = 5'b00011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    aluop_t      aluOp;
    logic        regWr;
    logic        aluSrc;
    logic        dREN;
    logic        dWEN;
    logic        pcSrc;
    logic [2:0]  rdSel;
    logic        jpSel;
    logic        shift;
    logic        isBranch;
    logic        atomic;
    logic        halt;
    logic        illegal;
  } decoded_instr_t;

  function automatic logic [31:0] imm_i(logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I (+ optional LR.W/SC.W) decoder producing the
// control bundle for the head of the decode buffer.
module decode_core
  import cpu_types_pkg::*;
#(
  parameter int ATOMIC_EN = 0
) (
  input  logic [31:0]    instr,
  output decoded_instr_t ctrl
);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] f5;
  logic       sh;
  logic       amo_ok;
  aluop_t     f3op;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign f5 = instr[31:27];
  assign sh = (f3 == F3_SLL) || (f3 == F3_SR);
  assign amo_ok = (ATOMIC_EN != 0) && (f3 == F3_WORD);

  // funct7 bit 5 picks SRA for both R and I shifts
  always_comb begin
    f3op = ALU_ADD;
    case (f3)
      F3_SLL:  f3op = ALU_SLL;
      F3_SLT:  f3op = ALU_SLT;
      F3_SLTU: f3op = ALU_SLTU;
      F3_XOR:  f3op = ALU_XOR;
      F3_SR:   f3op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
      F3_OR:   f3op = ALU_OR;
      F3_AND:  f3op = ALU_AND;
      default: f3op = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    ctrl.rs1   = instr[19:15];
    ctrl.rs2   = instr[24:20];
    ctrl.rd    = instr[11:7];
    ctrl.aluOp = ALU_ADD;
    unique case (1'b1)
      op == RTYPE: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          ctrl.regWr = 1'b1;
          ctrl.shift = sh;
          ctrl.aluOp = (f3 == F3_ADD && f7 == 7'h20) ? ALU_SUB : f3op;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      op == ITYPE: begin
        ctrl.regWr  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.imm    = imm_i(instr);
        ctrl.shift  = sh;
        ctrl.aluOp  = f3op;
      end
      op == LOAD: begin
        ctrl.regWr  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.dREN   = 1'b1;
        ctrl.rdSel  = RD_MEM;
        ctrl.imm    = imm_i(instr);
      end
      op == STORE: begin
        ctrl.dWEN   = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.imm    = imm_s(instr);
      end
      op == BRANCH: begin
        ctrl.isBranch = 1'b1;
        ctrl.imm      = imm_b(instr);
        ctrl.aluOp    = (f3 == BLT || f3 == BGE) ? ALU_SLT :
                        (f3 == BLTU || f3 == BGEU) ? ALU_SLTU :
                        ALU_SUB;
      end
      op == JAL: begin
        ctrl.regWr = 1'b1;
        ctrl.pcSrc = 1'b1;
        ctrl.rdSel = RD_PC4;
        ctrl.imm   = imm_j(instr);
      end
      op == JALR: begin
        ctrl.regWr  = 1'b1;
        ctrl.pcSrc  = 1'b1;
        ctrl.jpSel  = 1'b1;
        ctrl.aluSrc = 1'b1;
        ctrl.rdSel  = RD_PC4;
        ctrl.imm    = imm_i(instr);
      end
      op == LUI: begin
        ctrl.regWr = 1'b1;
        ctrl.rdSel = RD_IMM;
        ctrl.imm   = imm_u(instr);
      end
      op == AUIPC: begin
        ctrl.regWr = 1'b1;
        ctrl.rdSel = RD_AUIPC;
        ctrl.imm   = imm_u(instr);
      end
      op == ATOMIC: begin
        // address is rs1 + 0, so imm stays zero
        if (amo_ok && f5 == AMO_LR) begin
          ctrl.regWr  = 1'b1;
          ctrl.aluSrc = 1'b1;
          ctrl.dREN   = 1'b1;
          ctrl.atomic = 1'b1;
          ctrl.rdSel  = RD_MEM;
        end else if (amo_ok && f5 == AMO_SC) begin
          ctrl.regWr  = 1'b1;
          ctrl.aluSrc = 1'b1;
          ctrl.dWEN   = 1'b1;
          ctrl.atomic = 1'b1;
          ctrl.rdSel  = RD_MEM;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      op == HALT: ctrl.halt = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_buffer.sv
// Instruction queue between fetch and execute: decodes the head entry,
// locks intake after HALT until a flush or reset.
module decode_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ATOMIC_EN = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   f_valid,
  input  logic [31:0]            f_instr,
  input  logic [31:0]            f_pc,
  output logic                   f_ready,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [31:0]            d_pc,
  output decoded_instr_t         d_ctrl,
  output logic [$clog2(DEPTH):0] count,
  output logic                   halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [31:0]    mem_instr [DEPTH];
  logic [31:0]    mem_pc    [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  intake_t        state;
  intake_t        state_n;
  decoded_instr_t dec;

  assign halted  = (state == HALTED);
  assign f_ready = (count != FULL) && !halted;
  assign d_valid = (count != '0);
  assign push    = f_valid && f_ready;
  assign pop     = d_valid && d_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop)  rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: nothing reads an entry count does not cover
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= f_instr;
      mem_pc[wr_ptr]    <= f_pc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = RUN;
    end else if (state == RUN && push && f_instr[6:0] == HALT) begin
      state_n = HALTED;
    end
  end

  decode_core #(
    .ATOMIC_EN(ATOMIC_EN)
  ) u_dec (
    .instr(mem_instr[rd_ptr]),
    .ctrl (dec)
  );

  assign d_ctrl = d_valid ? dec : '0;
  assign d_pc   = d_valid ? mem_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_decode_buffer.sv
// Randomized bench for decode_buffer against a queue model, plus
// directed scenarios for fill, streaming, halt, flush and atomics.
module tb_decode_buffer;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic f_valid;
  logic d_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;

  logic f_ready0, d_valid0, halted0;
  logic f_ready1, d_valid1, halted1;
  logic [31:0] d_pc0, d_pc1;
  decoded_instr_t d_ctrl0, d_ctrl1;
  logic [$clog2(DEPTH):0] count0, count1;

  decode_buffer #(.DEPTH(DEPTH), .ATOMIC_EN(0)) dut0 (
    .CLK(clk), .RST(rst), .flush(flush),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .f_ready(f_ready0), .d_valid(d_valid0), .d_ready(d_ready),
    .d_pc(d_pc0), .d_ctrl(d_ctrl0), .count(count0), .halted(halted0)
  );

  decode_buffer #(.DEPTH(DEPTH), .ATOMIC_EN(1)) dut1 (
    .CLK(clk), .RST(rst), .flush(flush),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .f_ready(f_ready1), .d_valid(d_valid1), .d_ready(d_ready),
    .d_pc(d_pc1), .d_ctrl(d_ctrl1), .count(count1), .halted(halted1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  bit m_halt;
  logic [31:0] pc_ctr;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic decoded_instr_t ref_dec(logic [31:0] w, bit amo);
    decoded_instr_t c;
    logic [31:0] si, is, ib, ij, iu;
    logic [2:0] f3;
    logic [6:0] f7;
    logic shf;
    aluop_t tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    c   = '0;
    f3  = w[14:12];
    f7  = w[31:25];
    shf = (f3 == 3'd1) || (f3 == 3'd5);
    si  = $signed(w) >>> 20;
    is  = (si & 32'hFFFF_FFE0) | {27'b0, w[11:7]};
    ib  = (si & 32'hFFFF_F000) | {20'b0, w[7], w[30:25], w[11:8], 1'b0};
    ij  = (si & 32'hFFF0_0000) | {12'b0, w[19:12], w[20], w[30:21], 1'b0};
    iu  = w & 32'hFFFF_F000;
    c.rs1 = w[19:15];
    c.rs2 = w[24:20];
    c.rd  = w[11:7];
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          c.regWr = 1; c.shift = shf; c.aluOp = tbl[f3];
          if (f7 == 7'h20 && f3 == 3'd0) c.aluOp = ALU_SUB;
          if (f7 == 7'h20 && f3 == 3'd5) c.aluOp = ALU_SRA;
        end else c.illegal = 1;
      end
      7'h13: begin
        c.regWr = 1; c.aluSrc = 1; c.imm = si;
        c.shift = shf; c.aluOp = tbl[f3];
        if (f3 == 3'd5 && f7 == 7'h20) c.aluOp = ALU_SRA;
      end
      7'h03: begin
        c.regWr = 1; c.aluSrc = 1; c.dREN = 1;
        c.rdSel = 3'd1; c.imm = si;
      end
      7'h23: begin c.dWEN = 1; c.aluSrc = 1; c.imm = is; end
      7'h63: begin
        c.isBranch = 1; c.imm = ib;
        c.aluOp = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      7'h6F: begin c.regWr = 1; c.pcSrc = 1; c.rdSel = 3'd2; c.imm = ij; end
      7'h67: begin
        c.regWr = 1; c.pcSrc = 1; c.jpSel = 1;
        c.aluSrc = 1; c.rdSel = 3'd2; c.imm = si;
      end
      7'h37: begin c.regWr = 1; c.rdSel = 3'd3; c.imm = iu; end
      7'h17: begin c.regWr = 1; c.rdSel = 3'd4; c.imm = iu; end
      7'h2F: begin
        if (amo && f3 == 3'd2 && w[31:27] == 5'd2) begin
          c.regWr = 1; c.aluSrc = 1; c.dREN = 1;
          c.atomic = 1; c.rdSel = 3'd1;
        end else if (amo && f3 == 3'd2 && w[31:27] == 5'd3) begin
          c.regWr = 1; c.aluSrc = 1; c.dWEN = 1;
          c.atomic = 1; c.rdSel = 3'd1;
        end else c.illegal = 1;
      end
      7'h7F: c.halt = 1;
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  task automatic cmp_model();
    decoded_instr_t e0, e1;
    logic [31:0] epc;
    int n;
    n = q.size();
    e0 = '0; e1 = '0; epc = '0;
    if (n > 0) begin
      e0  = ref_dec(q[0].instr, 1'b0);
      e1  = ref_dec(q[0].instr, 1'b1);
      epc = q[0].pc;
    end
    check("count", 128'(count0), 128'(n));
    check("count_amo", 128'(count1), 128'(n));
    check("d_valid", 128'(d_valid0), 128'(n != 0));
    check("f_ready", 128'(f_ready0), 128'(n < DEPTH && !m_halt));
    check("f_ready_amo", 128'(f_ready1), 128'(n < DEPTH && !m_halt));
    check("halted", 128'(halted0), 128'(m_halt));
    check("d_pc", 128'(d_pc0), 128'(epc));
    check("d_ctrl", 128'(d_ctrl0), 128'(e0));
    check("d_ctrl_amo", 128'(d_ctrl1), 128'(e1));
  endtask

  task automatic step(bit fv, logic [31:0] w, bit dr, bit fl);
    bit acc, pp;
    f_valid = fv;
    f_instr = w;
    f_pc    = pc_ctr;
    d_ready = dr;
    flush   = fl;
    cmp_model();
    acc = fv && (q.size() < DEPTH) && !m_halt;
    pp  = (q.size() > 0) && dr;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_halt = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back('{w, pc_ctr});
        if (w[6:0] == 7'h7F) m_halt = 1;
        pc_ctr = pc_ctr + 32'd4;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    logic [6:0] ops [12];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
            7'h67, 7'h37, 7'h17, 7'h2F, 7'h33, 7'h13};
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 12) w[6:0] = ops[k];
    if (k == 0 || k == 10 || k == 11) begin
      if ($urandom_range(0, 7) != 0)
        w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    if (k == 9) begin
      if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010;
      if ($urandom_range(0, 3) != 0)
        w[31:27] = $urandom_range(0, 1) ? 5'd3 : 5'd2;
    end
    if (k == 12 && $urandom_range(0, 3) == 0) w[6:0] = 7'h7F;
    return w;
  endfunction

  initial begin
    rst = 1; flush = 0; f_valid = 0; d_ready = 0;
    f_instr = '0; f_pc = '0; pc_ctr = '0; m_halt = 0;
    #12;
    check("rst_count", 128'(count0), 128'(0));
    check("rst_d_valid", 128'(d_valid0), 128'(0));
    check("rst_f_ready", 128'(f_ready0), 128'(1));
    check("rst_halted", 128'(halted0), 128'(0));
    check("rst_d_ctrl", 128'(d_ctrl0), 128'(0));
    @(posedge clk); #1;
    rst = 0;

    // ADDI x1,x0,-5 lands on the head one edge after push
    step(1, 32'hFFB00093, 0, 0);
    check("addi_valid", 128'(d_valid0), 128'(1));
    check("addi_rd", 128'(d_ctrl0.rd), 128'(1));
    check("addi_imm", 128'(d_ctrl0.imm), 128'(32'hFFFF_FFFB));
    check("addi_alu", 128'(d_ctrl0.aluOp), 128'(ALU_ADD));
    check("addi_src", 128'(d_ctrl0.aluSrc), 128'(1));
    check("addi_count", 128'(count0), 128'(1));

    step(0, 0, 0, 1);
    pc_ctr = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("full_f_ready", 128'(f_ready0), 128'(0));
      step(1, 32'h00108093, 0, 0);
    end
    check("full_count", 128'(count0), 128'(4));
    for (int i = 0; i < 4; i++) begin
      check("pop_order", 128'(d_pc0), 128'(32'h1000 + 4 * i));
      step(0, 0, 1, 0);
    end

    step(0, 0, 0, 1);
    pc_ctr = 32'h2000;
    step(1, 32'h00208113, 0, 0);
    step(1, 32'h00208113, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("stream_pc", 128'(d_pc0), 128'(32'h2000 + 4 * i));
      step(1, 32'h00208113, 1, 0);
      check("stream_count", 128'(count0), 128'(2));
    end

    step(0, 0, 0, 1);
    step(1, 32'hFFFF_FFFF, 0, 0);
    check("halt_halted", 128'(halted0), 128'(1));
    check("halt_f_ready", 128'(f_ready0), 128'(0));
    step(1, 32'h002081B3, 0, 0);
    check("halt_blocked", 128'(count0), 128'(1));
    check("halt_head", 128'(d_ctrl0.halt), 128'(1));
    step(0, 0, 1, 0);
    check("halt_drained", 128'(count0), 128'(0));
    step(0, 0, 0, 1);
    check("halt_cleared", 128'(halted0), 128'(0));
    check("halt_ready", 128'(f_ready0), 128'(1));

    for (int i = 0; i < 3; i++) step(1, 32'h00308193, 0, 0);
    check("pre_flush", 128'(count0), 128'(3));
    step(1, 32'h00308193, 1, 1);
    check("flush_count", 128'(count0), 128'(0));
    check("flush_valid", 128'(d_valid0), 128'(0));

    step(1, 32'h100522AF, 0, 0);
    check("lr_illegal0", 128'(d_ctrl0.illegal), 128'(1));
    check("lr_dren0", 128'(d_ctrl0.dREN), 128'(0));
    check("lr_dren1", 128'(d_ctrl1.dREN), 128'(1));
    check("lr_atomic1", 128'(d_ctrl1.atomic), 128'(1));
    check("lr_illegal1", 128'(d_ctrl1.illegal), 128'(0));
    step(0, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        step(1, rand_instr(), 0, 0);
        rst = 1;
        #2;
        check("async_rst_count", 128'(count0), 128'(0));
        check("async_rst_valid", 128'(d_valid0), 128'(0));
        check("async_rst_ready", 128'(f_ready0), 128'(1));
        q.delete();
        m_halt = 0;
        @(posedge clk); #1;
        rst = 0;
        step(1, 32'h00100093, 0, 0);
        check("post_rst_push", 128'(count0), 128'(1));
      end
      step($urandom_range(0, 3) != 0, rand_instr(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    cmp_model();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
